// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one write port, r0 tied to zero,
// and per-register outstanding-write counters for RAW hazard detection.
// Optional write-through forwarding when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  output logic                 err
);

  logic [DW-1:0]    r_regs [NREG];
  logic [CNT_W-1:0] r_cnt  [NREG];
  logic             r_err;

  logic w_wr_v;
  logic w_iss_v;
  logic w_iss_ready;
  logic w_err_set;

  assign w_wr_v      = ce & wr_en & (wr_addr != '0);
  assign w_iss_v     = ce & iss_en;
  assign w_iss_ready = (r_cnt[iss_addr] != '1) || (iss_addr == '0);

  // Retiring write with no producer on record is a protocol error, unless a
  // same-cycle issue to that register supplies the producer it retires.
  assign w_err_set = (w_iss_v && !w_iss_ready) ||
                     (w_wr_v && (r_cnt[wr_addr] == '0) &&
                      !(w_iss_v && (iss_addr == wr_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else if (w_wr_v) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (w_iss_v && (iss_addr == AW'(r)) && !(w_wr_v && (wr_addr == AW'(r)))) begin
          if (r_cnt[r] != '1) r_cnt[r] <= r_cnt[r] + 1'b1;
        end else if (w_wr_v && (wr_addr == AW'(r)) && !(w_iss_v && (iss_addr == AW'(r)))) begin
          if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign iss_ready = w_iss_ready;
  assign err       = r_err;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    assign w_addr = rd_addr[gi*AW +: AW];

    always_comb begin
      w_data = r_regs[w_addr];
`ifdef REGFILE_SB_BYPASS_EN
      // Forwarding is suppressed during reset so reads stay zero.
      if (rst_n && w_wr_v && (w_addr == wr_addr)) w_data = wr_data;
`endif
      if (w_addr == '0) w_data = '0;
    end

    assign rd_data[gi*DW +: DW] = w_data;
    assign rd_busy[gi]          = (r_cnt[w_addr] != '0);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: the driver queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;
  localparam int DW = 32, NREG = 32, AW = 5, NUM_RD = 2, CNT_W = 2;
  localparam int K_DATA = 0, K_BUSY = 1, K_READY = 2, K_ERR = 3;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ce;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 iss_ready;
  logic                 err;

  regfile_sb #(.DW(DW), .NREG(NREG), .AW(AW), .NUM_RD(NUM_RD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_DATA:  act = rd_data[e.port*DW +: DW];
        K_BUSY:  act = {31'd0, rd_busy[e.port]};
        K_READY: act = {31'd0, iss_ready};
        default: act = {31'd0, err};
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic ex(input string n, input int k, input int p, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.port = p; e.val = v;
    q.push_back(e);
  endtask

  task automatic drv(input logic ie, input logic [4:0] ia, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra0, input logic [4:0] ra1);
    iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    #1;

    // In reset
    drv(0, 5'd7, 0, 0, 0, 5'd7, 5'd3);
    ex("rst_data0", K_DATA, 0, 0); ex("rst_busy0", K_BUSY, 0, 0);
    ex("rst_ready", K_READY, 0, 1); ex("rst_err", K_ERR, 0, 0);
    tick();
    rst_n = 1'b1;

    // Sweep all addresses on both ports
    for (int a = 0; a < NREG; a++) begin
      drv(0, 5'(a), 0, 0, 0, 5'(a), 5'(31 - a));
      ex("sweep_data0", K_DATA, 0, 0); ex("sweep_data1", K_DATA, 1, 0);
      ex("sweep_busy0", K_BUSY, 0, 0); ex("sweep_busy1", K_BUSY, 1, 0);
      ex("sweep_ready", K_READY, 0, 1); ex("sweep_err", K_ERR, 0, 0);
      tick();
    end

    // r5: issue, then write
    drv(1, 5'd5, 0, 0, 0, 5'd5, 5'd5);
    ex("r5_busy_pre", K_BUSY, 0, 0);
    tick();
    drv(0, 5'd5, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    ex("r5_busy_wr", K_BUSY, 0, 1);
    ex("r5_data_wr0", K_DATA, 0, BYP ? 32'hDEADBEEF : 32'h0);
    ex("r5_data_wr1", K_DATA, 1, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    drv(0, 5'd5, 0, 0, 0, 5'd5, 5'd5);
    ex("r5_busy_after", K_BUSY, 0, 0); ex("r5_data_after", K_DATA, 0, 32'hDEADBEEF);
    ex("r5_busy_after1", K_BUSY, 1, 0); ex("r5_err", K_ERR, 0, 0);
    tick();

    // r0: write and issue are ignored
    drv(1, 5'd0, 1, 5'd0, 32'h1234, 5'd0, 5'd0);
    ex("r0_data_wr", K_DATA, 0, 0); ex("r0_busy_wr", K_BUSY, 0, 0);
    ex("r0_ready", K_READY, 0, 1);
    tick();
    drv(0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
    ex("r0_data", K_DATA, 0, 0); ex("r0_busy", K_BUSY, 0, 0); ex("r0_err", K_ERR, 0, 0);
    tick();

    // r7: saturate counter
    for (int k = 0; k < 3; k++) begin
      drv(1, 5'd7, 0, 0, 0, 5'd7, 5'd0);
      ex("r7_ready_fill", K_READY, 0, 1);
      tick();
    end
    drv(0, 5'd7, 0, 0, 0, 5'd7, 5'd0);
    ex("r7_ready_sat", K_READY, 0, 0); ex("r7_busy_sat", K_BUSY, 0, 1);
    tick();
    drv(1, 5'd7, 0, 0, 0, 5'd7, 5'd0);
    ex("r7_err_before", K_ERR, 0, 0);
    tick();
    drv(0, 5'd7, 0, 0, 0, 5'd7, 5'd0);
    ex("r7_err_over", K_ERR, 0, 1); ex("r7_ready_held", K_READY, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(0, 5'd7, 1, 5'd7, 32'h70 + 32'(k), 5'd7, 5'd0);
      ex("r7_busy_drain", K_BUSY, 0, 1);
      ex("r7_ready_drain", K_READY, 0, (k == 0) ? 32'd0 : 32'd1);
      tick();
    end
    drv(0, 5'd7, 0, 0, 0, 5'd7, 5'd0);
    ex("r7_busy_done", K_BUSY, 0, 0); ex("r7_data_done", K_DATA, 0, 32'h72);
    ex("r7_err_sticky", K_ERR, 0, 1);
    tick();

    // r3: issue, then asynchronous reset mid-cycle
    drv(1, 5'd3, 0, 0, 0, 5'd3, 5'd7);
    tick();
    drv(0, 5'd3, 0, 0, 0, 5'd3, 5'd7);
    ex("r3_busy_pre", K_BUSY, 0, 1);
    tick();
    rst_n = 1'b0;
    drv(0, 5'd3, 1, 5'd3, 32'hAAAA5555, 5'd3, 5'd7);
    ex("midrst_busy", K_BUSY, 0, 0); ex("midrst_data3", K_DATA, 0, 0);
    ex("midrst_data7", K_DATA, 1, 0); ex("midrst_err", K_ERR, 0, 0);
    ex("midrst_ready", K_READY, 0, 1);
    tick();
    rst_n = 1'b1;

    // ce=0 masks issue, write and error detection
    ce = 1'b0;
    drv(1, 5'd4, 1, 5'd4, 32'h4444, 5'd4, 5'd0);
    ex("ce0_data_wr", K_DATA, 0, 0);
    tick();
    drv(0, 5'd4, 0, 0, 0, 5'd4, 5'd0);
    ex("ce0_data", K_DATA, 0, 0); ex("ce0_busy", K_BUSY, 0, 0); ex("ce0_err", K_ERR, 0, 0);
    tick();
    ce = 1'b1;

    // r9: simultaneous issue and write keep count; r10: underflow write
    drv(1, 5'd9, 0, 0, 0, 5'd9, 5'd10);
    tick();
    drv(1, 5'd9, 1, 5'd9, 32'h99, 5'd9, 5'd10);
    ex("r9_busy_both", K_BUSY, 0, 1);
    tick();
    drv(0, 5'd9, 1, 5'd10, 32'h1010, 5'd9, 5'd10);
    ex("r9_busy_kept", K_BUSY, 0, 1); ex("r9_data", K_DATA, 0, 32'h99);
    ex("r10_err_before", K_ERR, 0, 0);
    ex("r10_data_wr", K_DATA, 1, BYP ? 32'h1010 : 32'h0);
    tick();
    drv(0, 5'd9, 0, 0, 0, 5'd9, 5'd10);
    ex("r10_err", K_ERR, 0, 1); ex("r10_data", K_DATA, 1, 32'h1010);
    ex("r10_busy", K_BUSY, 1, 0); ex("r9_busy_still", K_BUSY, 0, 1);
    ex("r9_ready", K_READY, 0, 1);
    tick();

    tick();
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's 32x32 register block.
- Provides NUM_RD combinational read ports, one synchronous write port, and register 0 hardwired to zero.
- Adds a per-register pending-write scoreboard (outstanding-write counters) so decode can detect RAW hazards and stall.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
DW, 32, data width in bits
NREG, 32, number of registers (power of two, >=2)
AW, 5, address width; must equal log2(NREG)
NUM_RD, 2, number of read ports (1..4)
CNT_W, 2, width of each outstanding-write counter (max 2^CNT_W-1 outstanding writes per register)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; when 0, no state changes (array, counters, err all hold)
rd_addr  in  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW]
rd_data  out  NUM_RD*DW  read data, port i at bits [i*DW +: DW]
rd_busy  out  NUM_RD  1 = register on port i has >=1 outstanding write
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback register
wr_data  in  DW  writeback data
iss_en  in  1  instruction with destination iss_addr issues this cycle
iss_addr  in  AW  destination register of issuing instruction
iss_ready  out  1  0 = counter for iss_addr saturated; caller must not assert iss_en
err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst_n=0, asynchronous): all NREG registers = 0, all counters = 0, err = 0. While in reset: rd_data = 0, rd_busy = 0, iss_ready = 1, err = 0.
- Write: on clk rise with ce=1, wr_en=1, wr_addr!=0, reg[wr_addr] <= wr_data. Writes to address 0 are discarded.
- Read (combinational, zero latency):
  - rd_addr==0 -> rd_data = 0.
  - Otherwise rd_data = reg[rd_addr], subject to bypass (see Optional Feature).
- Counters: cnt[r] updated on clk rise with ce=1.
  - inc = iss_en and iss_addr==r and r!=0.
  - dec = wr_en and wr_addr==r and r!=0.
  - inc only -> cnt+1; dec only -> cnt-1; both -> unchanged (new producer replaces retiring one).
  - cnt[0] is constantly 0.
- rd_busy[i] = (cnt[rd_addr_i] != 0), combinational. Reflects registered counts only; a same-cycle write does not clear busy until the next cycle.
- iss_ready = (cnt[iss_addr] != all-ones) or (iss_addr==0), combinational. A same-cycle retiring write to iss_addr does not raise iss_ready.
- err is set (sticky until reset) on any of:
  - iss_en=1 while iss_ready=0; the counter holds at max, no wrap.
  - wr_en=1, wr_addr!=0 and cnt[wr_addr]==0 with no same-cycle issue to it; the data is still written and the counter holds at 0, no underflow.
- ce=0 masks iss_en and wr_en completely, including err detection.
- Reset asserted mid-operation clears everything immediately; in-flight writes are lost.
- Multiple read ports may address the same register; all return identical data and busy.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: write-through forwarding. If wr_en=1, ce=1, wr_addr!=0 and rd_addr_i==wr_addr, then rd_data_i = wr_data in the same cycle; rd_busy is unaffected.
- Undefined: rd_data always comes from the array; a write becomes visible the cycle after the clock edge.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_data 0, rd_busy 0, iss_ready 1, err 0.
- Issue to r5 once, next cycle write 0xDEADBEEF to r5:
  - During the write cycle rd_busy for r5 = 1, rd_data = 0xDEADBEEF with bypass, 0 without.
  - Cycle after: rd_busy = 0 and rd_data = 0xDEADBEEF in both builds.
- Issue r7 three times (CNT_W=2) -> iss_ready=0 for r7. Fourth issue -> err=1, cnt stays 3. Three writes -> rd_busy r7 = 0.
- Write 0x1234 to r0 with iss_en on r0 -> rd_data r0 = 0, rd_busy r0 = 0, err remains 0.
- Same-cycle issue and write to r9 with cnt=1 -> cnt stays 1 (rd_busy 1). Write to r10 with cnt=0 -> err=1, r10 = written data.
- Issue to r3, then assert rst_n=0 mid-cycle -> immediately rd_busy 0, r3 reads 0, err 0. With ce=0, issue/write to r4 -> no change.
